// File: rtl/snake_head_stepper.sv
// Snake head stepper: paces head movement with a step divider, applies the
// no-reversal rule, advances the head on the grid and detects wall collision.
// Optional build macro SNAKE_WRAP_EN: moves off an edge wrap to the opposite
// edge instead of ending the game.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - level; begins a run from IDLE or DEAD
//   pause         - level; freezes the step divider while running
//   direction     - requested heading: 00 up, 01 down, 10 right, 11 left
//   head_x/head_y - registered head column/row (row 0 is top)
//   heading       - current movement direction, same encoding as direction
//   step          - one-cycle pulse aligned with a new head position
//   game_over     - sticky wall-collision flag
//   running       - high while a run is in progress
module snake_head_stepper #(
  parameter int unsigned GRID_W   = 32,
  parameter int unsigned GRID_H   = 24,
  parameter int unsigned STEP_DIV = 25000000,
  parameter int unsigned START_X  = 16,
  parameter int unsigned START_Y  = 12,
  localparam int unsigned XW      = $clog2(GRID_W),
  localparam int unsigned YW      = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  input  logic [1:0]    direction,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [1:0]    heading,
  output logic          step,
  output logic          game_over,
  output logic          running
);

  localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div, div_nxt;
  logic [XW-1:0] x_nxt, move_x_c;
  logic [YW-1:0] y_nxt, move_y_c;
  logic [1:0]    heading_nxt, new_heading_c;
  logic          step_nxt, game_over_nxt;

  // Opposite direction keeps the current heading.
  always_comb begin
    new_heading_c = direction;
    if ((direction[1] == heading[1]) && (direction[0] != heading[0]))
      new_heading_c = heading;
  end

  // Candidate next position; edge moves produce the wrapped coordinate.
  always_comb begin
    move_x_c = head_x;
    move_y_c = head_y;
    case (new_heading_c)
      DIR_UP:    move_y_c = (head_y == '0) ? YW'(GRID_H - 1) : head_y - YW'(1);
      DIR_DOWN:  move_y_c = (head_y == YW'(GRID_H - 1)) ? '0 : head_y + YW'(1);
      DIR_RIGHT: move_x_c = (head_x == XW'(GRID_W - 1)) ? '0 : head_x + XW'(1);
      default:   move_x_c = (head_x == '0) ? XW'(GRID_W - 1) : head_x - XW'(1);
    endcase
  end

`ifndef SNAKE_WRAP_EN
  logic hit_c;

  // Wall hit detected by explicit edge checks, so no arithmetic wrap matters.
  always_comb begin
    case (new_heading_c)
      DIR_UP:    hit_c = (head_y == '0);
      DIR_DOWN:  hit_c = (head_y == YW'(GRID_H - 1));
      DIR_RIGHT: hit_c = (head_x == XW'(GRID_W - 1));
      default:   hit_c = (head_x == '0);
    endcase
  end
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div       <= '0;
      head_x    <= XW'(START_X);
      head_y    <= YW'(START_Y);
      heading   <= 2'b00;
      step      <= 1'b0;
      game_over <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nxt;
      div       <= div_nxt;
      head_x    <= x_nxt;
      head_y    <= y_nxt;
      heading   <= heading_nxt;
      step      <= step_nxt;
      game_over <= game_over_nxt;
      running   <= (state_nxt == RUN);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    div_nxt       = div;
    x_nxt         = head_x;
    y_nxt         = head_y;
    heading_nxt   = heading;
    step_nxt      = 1'b0;
    game_over_nxt = game_over;
    case (state)
      RUN: begin
        if (!pause) begin
          if (div == DW'(STEP_DIV - 1)) begin
            div_nxt     = '0;
            heading_nxt = new_heading_c;
`ifdef SNAKE_WRAP_EN
            x_nxt    = move_x_c;
            y_nxt    = move_y_c;
            step_nxt = 1'b1;
`else
            if (hit_c) begin
              game_over_nxt = 1'b1;
              state_nxt     = DEAD;
            end else begin
              x_nxt    = move_x_c;
              y_nxt    = move_y_c;
              step_nxt = 1'b1;
            end
`endif
          end else begin
            div_nxt = div + DW'(1);
          end
        end
      end
      default: begin
        // IDLE and DEAD: divider parked, outputs held until start.
        div_nxt = '0;
        if (start) begin
          state_nxt     = RUN;
          x_nxt         = XW'(START_X);
          y_nxt         = YW'(START_Y);
          heading_nxt   = direction;
          game_over_nxt = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_snake_head_stepper.sv
// Directed self-checking bench for snake_head_stepper on an 8x8 grid,
// STEP_DIV=4, start position (4,4).
module tb_snake_head_stepper;

  logic       clk = 1'b0;
  logic       rst, start, pause;
  logic [1:0] direction;
  logic [2:0] head_x;
  logic [2:0] head_y;
  logic [1:0] heading;
  logic       step, game_over, running;

  int checks = 0;
  int errors = 0;

  snake_head_stepper #(
    .GRID_W(8), .GRID_H(8), .STEP_DIV(4), .START_X(4), .START_Y(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .direction(direction), .head_x(head_x), .head_y(head_y),
    .heading(heading), .step(step), .game_over(game_over),
    .running(running)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_run(input logic [1:0] dir);
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    tick(1);
    rst = 1'b0;
    direction = dir;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    bit seen_step;
    rst = 1'b1; start = 1'b0; pause = 1'b0; direction = 2'b10;
    tick(2);
    rst = 1'b0;
    checks++;
    if ({head_x, head_y, heading, step, game_over, running} !== {3'd4, 3'd4, 2'b00, 3'b000}) begin
      errors++;
      $display("FAIL reset_values got x=%0d y=%0d hd=%b st=%b go=%b run=%b exp 4 4 00 0 0 0",
               head_x, head_y, heading, step, game_over, running);
    end
    seen_step = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (step) seen_step = 1'b1;
    end
    checks++;
    if ({seen_step, running, head_x, head_y} !== {2'b00, 3'd4, 3'd4}) begin
      errors++;
      $display("FAIL idle_hold got step_seen=%b run=%b x=%0d y=%0d exp 0 0 4 4",
               seen_step, running, head_x, head_y);
    end
  endtask

  task automatic test_right_wall();
    begin_run(2'b10);
    checks++;
    if ({running, heading, head_x, step} !== {1'b1, 2'b10, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL run_start got run=%b hd=%b x=%0d st=%b exp 1 10 4 0",
               running, heading, head_x, step);
    end
    for (int k = 1; k <= 3; k++) begin
      tick(3);
      checks++;
      if (step !== 1'b0) begin
        errors++;
        $display("FAIL early_step k=%0d got %b exp 0", k, step);
      end
      tick(1);
      checks++;
      if ({step, head_x, head_y} !== {1'b1, 3'(4 + k), 3'd4}) begin
        errors++;
        $display("FAIL right_step k=%0d got st=%b x=%0d y=%0d exp 1 %0d 4",
                 k, step, head_x, head_y, 4 + k);
      end
    end
    tick(4);
    checks++;
`ifdef SNAKE_WRAP_EN
    if ({step, head_x, game_over, running} !== {1'b1, 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL right_wrap got st=%b x=%0d go=%b run=%b exp 1 0 0 1",
               step, head_x, game_over, running);
    end
`else
    if ({step, head_x, game_over, running} !== {1'b0, 3'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL right_wall got st=%b x=%0d go=%b run=%b exp 0 7 1 0",
               step, head_x, game_over, running);
    end
    tick(8);
    checks++;
    if ({step, head_x, game_over, running} !== {1'b0, 3'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dead_frozen got st=%b x=%0d go=%b run=%b exp 0 7 1 0",
               step, head_x, game_over, running);
    end
`endif
  endtask

  task automatic test_reversal();
    begin_run(2'b10);
    direction = 2'b11;
    tick(4);
    checks++;
    if ({step, heading, head_x, head_y} !== {1'b1, 2'b10, 3'd5, 3'd4}) begin
      errors++;
      $display("FAIL reverse_block got st=%b hd=%b x=%0d y=%0d exp 1 10 5 4",
               step, heading, head_x, head_y);
    end
    direction = 2'b00;
    tick(4);
    checks++;
    if ({step, heading, head_x, head_y} !== {1'b1, 2'b00, 3'd5, 3'd3}) begin
      errors++;
      $display("FAIL turn_up got st=%b hd=%b x=%0d y=%0d exp 1 00 5 3",
               step, heading, head_x, head_y);
    end
  endtask

  task automatic test_pause();
    bit seen_step;
    begin_run(2'b00);
    tick(2);
    pause = 1'b1;
    seen_step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (step) seen_step = 1'b1;
    end
    checks++;
    if ({seen_step, head_y, running} !== {1'b0, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL pause_hold got step_seen=%b y=%0d run=%b exp 0 4 1",
               seen_step, head_y, running);
    end
    pause = 1'b0;
    tick(1);
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL pause_release1 got st=%b exp 0", step);
    end
    tick(1);
    checks++;
    if ({step, head_y} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL pause_release2 got st=%b y=%0d exp 1 3", step, head_y);
    end
  endtask

  task automatic test_top_wall();
    begin_run(2'b00);
    for (int k = 1; k <= 4; k++) begin
      tick(4);
      checks++;
      if ({step, head_y, head_x} !== {1'b1, 3'(4 - k), 3'd4}) begin
        errors++;
        $display("FAIL up_step k=%0d got st=%b y=%0d x=%0d exp 1 %0d 4",
                 k, step, head_y, head_x, 4 - k);
      end
    end
    tick(4);
    checks++;
`ifdef SNAKE_WRAP_EN
    if ({step, head_y, game_over} !== {1'b1, 3'd7, 1'b0}) begin
      errors++;
      $display("FAIL top_wrap got st=%b y=%0d go=%b exp 1 7 0", step, head_y, game_over);
    end
`else
    if ({step, head_y, game_over, running} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL top_wall got st=%b y=%0d go=%b run=%b exp 0 0 1 0",
               step, head_y, game_over, running);
    end
    direction = 2'b10;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++;
    if ({head_x, head_y, game_over, running, heading} !== {3'd4, 3'd4, 1'b0, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL restart got x=%0d y=%0d go=%b run=%b hd=%b exp 4 4 0 1 10",
               head_x, head_y, game_over, running, heading);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    begin_run(2'b10);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({head_x, head_y, heading, step, game_over, running} !== {3'd4, 3'd4, 2'b00, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid_run got x=%0d y=%0d hd=%b st=%b go=%b run=%b exp 4 4 00 0 0 0",
               head_x, head_y, heading, step, game_over, running);
    end
    direction = 2'b10;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    checks++;
    if ({step, head_x} !== {1'b0, 3'd4}) begin
      errors++;
      $display("FAIL div_restart_early got st=%b x=%0d exp 0 4", step, head_x);
    end
    tick(1);
    checks++;
    if ({step, head_x} !== {1'b1, 3'd5}) begin
      errors++;
      $display("FAIL div_restart_step got st=%b x=%0d exp 1 5", step, head_x);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; direction = 2'b00;
    test_reset();
    test_right_wall();
    test_reversal();
    test_pause();
    test_top_wall();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
